// File: rtl/ram_hs_param.sv
// Byte-addressable memory behind a MOV/MOC four-phase handshake.
// Wait states, endianness, sign extension and access checking.
module ram_hs_param #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int BIG_ENDIAN  = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        TYPE,
  input  logic              SIGNED,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MOC,
  output logic              ERR,
  output logic              BUSY
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAITV = 4'(WAIT_CYCLES);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);
  localparam bit BE = (BIG_ENDIAN != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

  state_t state;
  logic [3:0] cnt;

  logic [ADDR_W-1:0] a_addr;
  logic              a_rw;
  logic [1:0]        a_type;
  logic              a_sgn;
  logic [31:0]       a_din;

  logic [7:0] mem [DEPTH];

  logic [ADDR_W-1:0] e_addr;
  logic              e_rw;
  logic [1:0]        e_type;
  logic              e_sgn;
  logic [31:0]       e_din;

  logic [1:0]      span;
  logic [ADDR_W:0] last;
  logic            is_b;
  logic            is_h;
  logic            is_w;
  logic            bad;
  logic            commit;

  logic [AW-1:0] i0;
  logic [AW-1:0] i1;
  logic [AW-1:0] i2;
  logic [AW-1:0] i3;
  logic [7:0]    b0;
  logic [7:0]    b1;
  logic [7:0]    b2;
  logic [7:0]    b3;
  logic [15:0]   hw;
  logic [31:0]   rdata;

  // Live inputs while idle (zero-wait commit), captured copy otherwise
  always_comb begin
    e_addr = ADDR;
    e_rw   = RW;
    e_type = TYPE;
    e_sgn  = SIGNED;
    e_din  = DATA_IN;
    if (state != ST_IDLE) begin
      e_addr = a_addr;
      e_rw   = a_rw;
      e_type = a_type;
      e_sgn  = a_sgn;
      e_din  = a_din;
    end
  end

  // Size decode and rejection of reserved, misaligned, out-of-range
  always_comb begin
    is_b = (e_type == 2'b00);
    is_h = (e_type == 2'b01);
    is_w = (e_type == 2'b10);
    span = 2'd0;
    unique case (1'b1)
      is_w:    span = 2'd3;
      is_h:    span = 2'd1;
      default: span = 2'd0;
    endcase
    last = {1'b0, e_addr} + {{(ADDR_W-1){1'b0}}, span};
    bad  = (e_type == 2'b11)
         | (is_h & e_addr[0])
         | (is_w & (e_addr[1:0] != 2'b00))
         | (last > LAST);
  end

  // Byte lanes of the access and the extended read value
  always_comb begin
    i0 = e_addr[AW-1:0];
    i1 = i0 + AW'(1);
    i2 = i0 + AW'(2);
    i3 = i0 + AW'(3);
    b0 = mem[i0];
    b1 = mem[i1];
    b2 = mem[i2];
    b3 = mem[i3];
    hw = BE ? {b0, b1} : {b1, b0};
    rdata = 32'h0;
    unique case (1'b1)
      is_w:    rdata = BE ? {b0, b1, b2, b3}
                          : {b3, b2, b1, b0};
      is_h:    rdata = {{16{e_sgn & hw[15]}}, hw};
      is_b:    rdata = {{24{e_sgn & b0[7]}}, b0};
      default: rdata = 32'h0;
    endcase
  end

  // Edge on which the FSM enters DONE; CLR suppresses it
  assign commit = !CLR
    & (((state == ST_IDLE) & MOV & (WAITV == 4'd0))
    | ((state == ST_BUSY) & (cnt <= 4'd1)));

  // Array write on commit; no reset so preloaded contents survive CLR
  always_ff @(posedge CLK) begin
    if (commit && !bad && !e_rw) begin
      unique case (1'b1)
        is_w: begin
          if (BE) begin
            mem[i0] <= e_din[31:24];
            mem[i1] <= e_din[23:16];
            mem[i2] <= e_din[15:8];
            mem[i3] <= e_din[7:0];
          end else begin
            mem[i0] <= e_din[7:0];
            mem[i1] <= e_din[15:8];
            mem[i2] <= e_din[23:16];
            mem[i3] <= e_din[31:24];
          end
        end
        is_h: begin
          if (BE) begin
            mem[i0] <= e_din[15:8];
            mem[i1] <= e_din[7:0];
          end else begin
            mem[i0] <= e_din[7:0];
            mem[i1] <= e_din[15:8];
          end
        end
        is_b: mem[i0] <= e_din[7:0];
        default: ;
      endcase
    end
  end

  // Handshake FSM with registered MOC/ERR/BUSY/DATA_OUT
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      MOC      <= 1'b0;
      ERR      <= 1'b0;
      BUSY     <= 1'b0;
      DATA_OUT <= 32'h0;
      a_addr   <= '0;
      a_rw     <= 1'b0;
      a_type   <= 2'b00;
      a_sgn    <= 1'b0;
      a_din    <= 32'h0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (MOV) begin
            a_addr <= ADDR;
            a_rw   <= RW;
            a_type <= TYPE;
            a_sgn  <= SIGNED;
            a_din  <= DATA_IN;
            cnt    <= WAITV;
            if (WAITV == 4'd0) begin
              state <= ST_DONE;
              MOC   <= 1'b1;
              ERR   <= bad;
              if (e_rw && !bad) DATA_OUT <= rdata;
            end else begin
              state <= ST_BUSY;
              BUSY  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (cnt <= 4'd1) begin
            cnt   <= 4'd0;
            state <= ST_DONE;
            BUSY  <= 1'b0;
            MOC   <= 1'b1;
            ERR   <= bad;
            if (e_rw && !bad) DATA_OUT <= rdata;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (!MOV) begin
            state <= ST_IDLE;
            MOC   <= 1'b0;
            ERR   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_hs_param.sv
// Directed bench for ram_hs_param: two instances,
// WAIT=2/big-endian and WAIT=0/little-endian.
module tb_ram_hs_param;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic        mov  [2];
  logic        rw   [2];
  logic [1:0]  ty   [2];
  logic        sgn  [2];
  logic [31:0] addr [2];
  logic [31:0] din  [2];
  logic [31:0] dout [2];
  logic        moc  [2];
  logic        err  [2];
  logic        busy [2];

  int n_chk = 0;
  int n_err = 0;

  ram_hs_param #(
    .DEPTH(256), .ADDR_W(32),
    .WAIT_CYCLES(2), .BIG_ENDIAN(1)
  ) u0 (
    .CLK(clk), .CLR(clr), .MOV(mov[0]), .RW(rw[0]),
    .TYPE(ty[0]), .SIGNED(sgn[0]), .ADDR(addr[0]),
    .DATA_IN(din[0]), .DATA_OUT(dout[0]),
    .MOC(moc[0]), .ERR(err[0]), .BUSY(busy[0])
  );

  ram_hs_param #(
    .DEPTH(256), .ADDR_W(32),
    .WAIT_CYCLES(0), .BIG_ENDIAN(0)
  ) u1 (
    .CLK(clk), .CLR(clr), .MOV(mov[1]), .RW(rw[1]),
    .TYPE(ty[1]), .SIGNED(sgn[1]), .ADDR(addr[1]),
    .DATA_IN(din[1]), .DATA_OUT(dout[1]),
    .MOC(moc[1]), .ERR(err[1]), .BUSY(busy[1])
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One handshake; inputs are scrambled after capture
  task automatic op(input string tag, input int s,
                    input logic r, input logic [1:0] t,
                    input logic sg, input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [31:0] exp_q,
                    input logic exp_e, input int hold);
    int lat;
    int good;
    int exp_lat;
    exp_lat = (s == 0) ? 3 : 1;
    rw[s] = r; ty[s] = t; sgn[s] = sg;
    addr[s] = a; din[s] = d; mov[s] = 1'b1;
    lat = 0;
    good = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      addr[s] = ~a; din[s] = ~d; rw[s] = ~r;
      ty[s] = ~t; sgn[s] = ~sg;
      @(negedge clk);
    end while (!moc[s] && lat < 20);
    chk({tag, "_moc"}, 32'(moc[s]), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(err[s]), 32'(exp_e));
    if (r) chk({tag, "_data"}, dout[s], exp_q);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (moc[s] && !busy[s] && dout[s] === exp_q)
        good++;
    end
    if (hold > 0) chk({tag, "_hold"}, 32'(good), 32'(hold));
    mov[s] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_drop"}, 32'(moc[s]), 32'd0);
    chk({tag, "_edrop"}, 32'(err[s]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mov[i] = 1'b0; rw[i] = 1'b0; ty[i] = 2'b00;
      sgn[i] = 1'b0; addr[i] = 32'h0; din[i] = 32'h0;
    end
    clr = 1'b1;
    mov[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_moc", 32'(moc[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_dout", dout[0], 32'h0);
    chk("rst_moc1", 32'(moc[1]), 32'd0);
    mov[0] = 1'b0;
    clr = 1'b0;
    @(negedge clk);

    op("wr_w0", 0, 0, 2'd2, 0, 32'h0, 32'hE3A01005,
       32'h0, 0, 0);
    op("rd_w0", 0, 1, 2'd2, 0, 32'h0, 32'h0,
       32'hE3A01005, 0, 0);
    op("rd_b1", 0, 1, 2'd0, 0, 32'h1, 32'h0,
       32'h000000A0, 0, 0);
    op("rd_b3", 0, 1, 2'd0, 1, 32'h3, 32'h0,
       32'h00000005, 0, 0);
    op("wr_w4", 0, 0, 2'd2, 0, 32'h4, 32'h11223344,
       32'h0, 0, 0);
    op("wr_b5", 0, 0, 2'd0, 0, 32'h5, 32'h55AACC80,
       32'h0, 0, 0);
    op("rd_b5s", 0, 1, 2'd0, 1, 32'h5, 32'h0,
       32'hFFFFFF80, 0, 0);
    op("rd_b5u", 0, 1, 2'd0, 0, 32'h5, 32'h0,
       32'h00000080, 0, 0);
    op("rd_w4", 0, 1, 2'd2, 0, 32'h4, 32'h0,
       32'h11803344, 0, 0);
    op("rd_h3", 0, 1, 2'd1, 0, 32'h3, 32'h0,
       32'h11803344, 1, 0);
    op("wr_w252", 0, 0, 2'd2, 0, 32'd252, 32'hDEADBEEF,
       32'h0, 0, 0);
    op("wr_w254", 0, 0, 2'd2, 0, 32'd254, 32'h01020304,
       32'h0, 1, 0);
    op("rd_w252", 0, 1, 2'd2, 0, 32'd252, 32'h0,
       32'hDEADBEEF, 0, 0);
    op("rd_h254", 0, 1, 2'd1, 0, 32'd254, 32'h0,
       32'h0000BEEF, 0, 0);
    op("rd_b255", 0, 1, 2'd0, 1, 32'd255, 32'h0,
       32'hFFFFFFEF, 0, 0);
    op("rd_w256", 0, 1, 2'd2, 0, 32'd256, 32'h0,
       32'hFFFFFFEF, 1, 0);
    op("rd_bhi", 0, 1, 2'd0, 0, 32'h80000000, 32'h0,
       32'hFFFFFFEF, 1, 0);
    op("rd_t11", 0, 1, 2'd3, 0, 32'h0, 32'h0,
       32'hFFFFFFEF, 1, 0);
    op("wr_w6", 0, 0, 2'd2, 0, 32'h6, 32'hCAFEF00D,
       32'h0, 1, 0);
    op("rd_w4b", 0, 1, 2'd2, 0, 32'h4, 32'h0,
       32'h11803344, 0, 0);
    op("hold", 0, 1, 2'd2, 0, 32'h0, 32'h0,
       32'hE3A01005, 0, 10);
    op("wr_w8", 0, 0, 2'd2, 0, 32'h8, 32'hA5A55A5A,
       32'h0, 0, 0);

    rw[0] = 1'b0; ty[0] = 2'd2; sgn[0] = 1'b0;
    addr[0] = 32'h8; din[0] = 32'h11223344;
    mov[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("clr_busy_pre", 32'(busy[0]), 32'd1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_busy", 32'(busy[0]), 32'd0);
    chk("clr_moc", 32'(moc[0]), 32'd0);
    chk("clr_dout", dout[0], 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mov[0] = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    op("rd_w8", 0, 1, 2'd2, 0, 32'h8, 32'h0,
       32'hA5A55A5A, 0, 0);

    op("le_wr_c", 1, 0, 2'd2, 0, 32'hC, 32'h11223344,
       32'h0, 0, 0);
    op("le_rd_c", 1, 1, 2'd2, 0, 32'hC, 32'h0,
       32'h11223344, 0, 0);
    op("le_rd_bc", 1, 1, 2'd0, 0, 32'hC, 32'h0,
       32'h00000044, 0, 0);
    op("le_rd_hc", 1, 1, 2'd1, 0, 32'hC, 32'h0,
       32'h00003344, 0, 0);
    op("le_rd_h1", 1, 1, 2'd1, 0, 32'hD, 32'h0,
       32'h00003344, 1, 0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
